// File: rtl/ifetch_pkg.sv
// Shared widths, fetch FSM encoding and PC helpers for the instruction fetch unit.
`ifndef IDWidth
`define IDWidth 32
`endif
`ifndef AddressWidth
`define AddressWidth 32
`endif

package ifetch_pkg;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_BUSY = 2'd1,
        IF_DROP = 2'd2
    } if_state_e;

    localparam logic [`AddressWidth-1:0] PC_STEP = `AddressWidth'(4);

    function automatic logic [`AddressWidth-1:0] align_pc(input logic [`AddressWidth-1:0] pc);
        return {pc[`AddressWidth-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_icache.sv
// Direct-mapped instruction cache: word-indexed valid/tag/data arrays with
// combinational lookup and a single synchronous fill port.
`ifndef IDWidth
`define IDWidth 32
`endif
`ifndef AddressWidth
`define AddressWidth 32
`endif

module ifetch_icache #(
    parameter int LINES = 64
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic [`AddressWidth-3:0]  lookup_word_i,
    output logic                      hit_o,
    output logic [`IDWidth-1:0]       data_o,
    input  logic                      fill_en_i,
    input  logic [`AddressWidth-3:0]  fill_word_i,
    input  logic [`IDWidth-1:0]       fill_data_i
);

    localparam int IW = $clog2(LINES);
    localparam int TW = `AddressWidth - 2 - IW;

    logic [LINES-1:0]    valid_q;
    logic [TW-1:0]       tag_q  [LINES];
    logic [`IDWidth-1:0] data_q [LINES];

    logic [IW-1:0] lk_idx;
    logic [IW-1:0] fl_idx;

    assign lk_idx = lookup_word_i[IW-1:0];
    assign fl_idx = fill_word_i[IW-1:0];

    assign hit_o  = valid_q[lk_idx] && (tag_q[lk_idx] == lookup_word_i[`AddressWidth-3:IW]);
    assign data_o = data_q[lk_idx];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q <= '0;
        end else if (fill_en_i) begin
            valid_q[fl_idx] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays carry no reset; the valid bits alone qualify them,
    // so they stay plain RAM instead of a wide reset flop bank.
    always_ff @(posedge clk_in) begin
        if (fill_en_i) begin
            tag_q[fl_idx]  <= fill_word_i[`AddressWidth-3:IW];
            data_q[fl_idx] <= fill_data_i;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: PC, memory request FSM and instruction queue push.
// Define IF_ICACHE_EN to serve fetches from the direct-mapped ifetch_icache.
`ifndef IDWidth
`define IDWidth 32
`endif
`ifndef AddressWidth
`define AddressWidth 32
`endif

module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [`AddressWidth-1:0] RESET_PC     = 32'h0,
    parameter int                       ICACHE_LINES = 64
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      rdy_in,
    output logic                      if_instqueue_en_out,
    output logic [`IDWidth-1:0]       if_instqueue_inst_out,
    output logic [`AddressWidth-1:0]  if_instqueue_pc_out,
    input  logic                      instqueue_if_rdy_in,
    output logic                      if_mem_en_out,
    output logic [`AddressWidth-1:0]  if_mem_addr_out,
    input  logic                      mem_if_valid_in,
    input  logic [`IDWidth-1:0]       mem_if_data_in,
    input  logic                      rob_if_rst_in,
    input  logic [`AddressWidth-1:0]  rob_if_pc_in,
    input  logic                      decoder_if_rst_in,
    input  logic [`AddressWidth-1:0]  decoder_if_pc_in,
    input  logic                      bp_if_rst_in,
    input  logic [`AddressWidth-1:0]  bp_if_pc_in
);

    if_state_e               state_q, state_d;
    logic [`AddressWidth-1:0] pc_q, pc_d;
    logic                     push_en_q, push_en_d;
    logic [`IDWidth-1:0]      push_inst_q, push_inst_d;
    logic [`AddressWidth-1:0] push_pc_q, push_pc_d;
    logic                     mem_en_q, mem_en_d;
    logic [`AddressWidth-1:0] mem_addr_q, mem_addr_d;

    logic                     flush;
    logic [`AddressWidth-1:0] flush_target;
    logic                     hit;
    logic [`IDWidth-1:0]      hit_data;

`ifdef IF_ICACHE_EN
    // Every response fills, including stale ones being discarded in DROP.
    logic fill_en;
    assign fill_en = rdy_in && mem_en_q && mem_if_valid_in;

    ifetch_icache #(
        .LINES (ICACHE_LINES)
    ) u_icache (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .lookup_word_i (pc_q[`AddressWidth-1:2]),
        .hit_o         (hit),
        .data_o        (hit_data),
        .fill_en_i     (fill_en),
        .fill_word_i   (mem_addr_q[`AddressWidth-1:2]),
        .fill_data_i   (mem_if_data_in)
    );
`else
    logic [31:0] unused_icache_lines;
    assign unused_icache_lines = ICACHE_LINES;
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_comb begin
        flush = rdy_in && (rob_if_rst_in || decoder_if_rst_in || bp_if_rst_in);
        if (rob_if_rst_in)          flush_target = rob_if_pc_in;
        else if (decoder_if_rst_in) flush_target = decoder_if_pc_in;
        else                        flush_target = bp_if_pc_in;
    end

    // NOTE: every next-state signal takes its hold value first, so no path
    // through this block can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        push_en_d   = push_en_q;
        push_inst_d = push_inst_q;
        push_pc_d   = push_pc_q;
        mem_en_d    = mem_en_q;
        mem_addr_d  = mem_addr_q;

        if (rdy_in) begin
            push_en_d = 1'b0;
            if (flush) begin
                pc_d = align_pc(flush_target);
                if (state_q != IF_IDLE) begin
                    // Memory cannot abort: keep requesting until the stale word arrives.
                    if (mem_if_valid_in) begin
                        mem_en_d = 1'b0;
                        state_d  = IF_IDLE;
                    end else begin
                        state_d  = IF_DROP;
                    end
                end
            end else begin
                unique case (state_q)
                    IF_IDLE: begin
                        if (instqueue_if_rdy_in && !push_en_q) begin
                            if (hit) begin
                                push_en_d   = 1'b1;
                                push_inst_d = hit_data;
                                push_pc_d   = pc_q;
                                pc_d        = pc_q + PC_STEP;
                            end else begin
                                mem_en_d    = 1'b1;
                                mem_addr_d  = pc_q;
                                state_d     = IF_BUSY;
                            end
                        end
                    end
                    IF_BUSY: begin
                        if (mem_if_valid_in) begin
                            push_en_d   = 1'b1;
                            push_inst_d = mem_if_data_in;
                            push_pc_d   = pc_q;
                            pc_d        = pc_q + PC_STEP;
                            mem_en_d    = 1'b0;
                            state_d     = IF_IDLE;
                        end
                    end
                    IF_DROP: begin
                        if (mem_if_valid_in) begin
                            mem_en_d = 1'b0;
                            state_d  = IF_IDLE;
                        end
                    end
                    default: state_d = IF_IDLE;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IF_IDLE;
            pc_q        <= RESET_PC;
            push_en_q   <= 1'b0;
            push_inst_q <= '0;
            push_pc_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            push_en_q   <= push_en_d;
            push_inst_q <= push_inst_d;
            push_pc_q   <= push_pc_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    assign if_instqueue_en_out   = push_en_q;
    assign if_instqueue_inst_out = push_inst_q;
    assign if_instqueue_pc_out   = push_pc_q;
    assign if_mem_en_out         = mem_en_q;
    assign if_mem_addr_out       = mem_addr_q;

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit: the producer side of the instruction queue push interface. It holds the fetch PC, requests 32-bit instruction words from the memory controller, optionally serves them from a small direct-mapped instruction cache, and pushes {instruction, PC} pairs into the instruction queue under its ready back-pressure. It redirects the PC on flushes from the reorder buffer, decoder or branch predictor, the same three sources that clear the queue.

## Interface
Parameters:
- RESET_PC, 32'h0, fetch PC after reset
- ICACHE_LINES, 64, cache depth in words (power of two); only used with IF_ICACHE_EN

Ports:
- clk_in  input  1  clock, rising edge
- rst_n_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global enable; low freezes all state
- if_instqueue_en_out  output  1  push strobe, one cycle per instruction
- if_instqueue_inst_out  output  `IDWidth  instruction word
- if_instqueue_pc_out  output  `AddressWidth  PC of that instruction
- instqueue_if_rdy_in  input  1  queue has at least one free slot
- if_mem_en_out  output  1  fetch request, level, held until response
- if_mem_addr_out  output  `AddressWidth  word address, stable while requesting
- mem_if_valid_in  input  1  one-cycle response strobe
- mem_if_data_in  input  `IDWidth  response word
- rob_if_rst_in / rob_if_pc_in  input  1 / `AddressWidth  mispredict redirect
- decoder_if_rst_in / decoder_if_pc_in  input  1 / `AddressWidth  decode-time redirect
- bp_if_rst_in / bp_if_pc_in  input  1 / `AddressWidth  predicted-taken redirect

## Operation
- Reset (rst_n_in low, any time): pc=RESET_PC, state IDLE, all outputs 0, cache valid bits cleared.
- States: IDLE, BUSY (request outstanding), DROP (stale request outstanding).
- Flush = any *_rst_in high with rdy_in high. Target priority: rob > decoder > bp. On flush: pc<=target, if_instqueue_en_out<=0, no new request or push that cycle. From IDLE stays IDLE. From BUSY goes to DROP: memory cannot abort, so if_mem_en_out and the old address stay asserted until mem_if_valid_in, and the data is discarded (not pushed). A flush in DROP only updates pc.
- Issue condition in IDLE, no flush: instqueue_if_rdy_in && !if_instqueue_en_out. The second term prevents overrunning the queue's last slot on stale ready.
- Miss (or macro off): if_mem_en_out<=1, if_mem_addr_out<=pc, go BUSY.
- BUSY and mem_if_valid_in: push {mem_if_data_in, pc}, pc<=pc+4, if_mem_en_out<=0, go IDLE.
- DROP and mem_if_valid_in: if_mem_en_out<=0, go IDLE, no push.
- PC arithmetic is 32-bit, wraps at 2^32. The low two bits are forced to 0 on redirect.
- rdy_in low: no state or output changes. The memory controller is gated by the same rdy_in.

## Timing
- All outputs registered.
- Miss: decision in cycle t; request visible t+1. Response in cycle r ≥ t+1; push visible r+1.
- Hit: decision in t; push visible t+1. Next issue is no earlier than t+2, so peak throughput is one instruction per 2 cycles.
- Flush in cycle t: pushes are suppressed from t+1. A push visible during t is dropped by the queue's own flush.
- After leaving DROP, the first request to the new pc is visible one cycle later.

## Configuration
- IF_ICACHE_EN defined: direct-mapped cache of ICACHE_LINES words.
  - Index pc[log2(ICACHE_LINES)+1:2]; tag is the remaining upper bits plus a valid bit.
  - Hit check happens in IDLE at issue.
  - Every mem_if_valid_in response fills its line, including responses discarded in DROP.
  - Flushes do not invalidate the cache.
- Undefined: no cache storage; every fetch is a memory request. Interface is unchanged.

## Structure
- `IDWidth, `AddressWidth and the state encodings go in the shared constant header.
- One sub-module, icache: valid/tag/data arrays, combinational lookup, synchronous fill, async reset of valid bits. It is instantiated only under IF_ICACHE_EN.

## Test plan
- Reset, then queue ready, memory returns 32'h00000013 after 3 cycles -> request addr 0x0; push inst 0x13 pc 0x0; next request addr 0x4.
- instqueue_if_rdy_in low for 10 cycles -> no if_mem_en_out rise, no push, pc holds 0x8.
- bp_if_rst_in with pc 0x100 while BUSY on 0x10 -> request on 0x10 held until valid; response not pushed; next request addr 0x100.
- rob_if_rst_in (0x200) and decoder_if_rst_in (0x300) in the same cycle -> next fetch addr 0x200.
- IF_ICACHE_EN: loop jumping back to 0x40 twice -> second pass has no memory request and a push 1 cycle after issue; with macro off, every pass requests memory.
- rst_n_in low mid-BUSY -> outputs 0 immediately, pc=RESET_PC, state IDLE.
